// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives the fetch PC, talks to instruction memory with a
// req/ready handshake, and feeds the IF/ID register with stall and redirect handling.
//
// state | meaning
// FETCH | request outstanding to instruction memory
// HOLD  | fetched word parked in buffer while downstream is stalled
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_address,
    output logic [31:0] pc,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    logic        transfer;
    logic        redirect;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] redirect_target;

    // Gated by reset so the request drops asynchronously with it.
    assign imem_req  = (state_q == FETCH) && !reset;
    assign imem_addr = pc_q;
    assign transfer  = imem_req && imem_ready;
    assign pc_plus4  = pc_q + 32'd4;

    assign branch_target   = pc4_q + {{14{branch_offset[15]}}, branch_offset, 2'b00};
    assign jump_target     = {pc4_q[31:28], jump_address, 2'b00};
    assign redirect_target = jump ? jump_target : branch_target;
    assign redirect        = (jump || branch_taken) && valid_q && !stall;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        buf_d   = buf_q;
        inst_d  = inst_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (stall) begin
            if (state_q == FETCH && transfer) begin
                buf_d   = imem_data;
                pc_d    = pc_plus4;
                state_d = HOLD;
            end
        end else if (redirect) begin
            pc_d    = redirect_target;
            valid_d = 1'b0;
            state_d = FETCH;
        end else if (state_q == FETCH) begin
            if (transfer) begin
                inst_d  = imem_data;
                pc4_d   = pc_plus4;
                valid_d = 1'b1;
                pc_d    = pc_plus4;
            end else begin
                valid_d = 1'b0;
            end
        end else begin
            // pc already advanced past the buffered word, so it is that word's PC+4.
            inst_d  = buf_q;
            pc4_d   = pc_q;
            valid_d = 1'b1;
            state_d = FETCH;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            buf_q   <= 32'h0;
            inst_q  <= 32'h0;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            inst_q  <= inst_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign pc                = pc_q;
    assign if_id_instruction = inst_q;
    assign if_id_pc4         = pc4_q;
    assign if_id_valid       = valid_q;

endmodule
